polar_to_cart9: RTL

POLAR_TO_CART9 -- requirements
Module: polar_to_cart9

---
 rtl/polar_to_cart9.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/polar_to_cart9.sv
// Iterative CORDIC polar-to-Cartesian converter: 9-bit magnitude and angle in,
// 10-bit signed X/Y out, one conversion per 13 busy cycles.
module polar_to_cart9 #(
  parameter int unsigned ITER = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [8:0]        R,
  input  logic signed [8:0] THETA,
  output logic              BUSY,
  output logic              DONE,
  output logic signed [9:0] X,
  output logic signed [9:0] Y
);

  typedef enum logic [1:0] {StIdle, StLoad, StIter, StOut} state_e;

  localparam logic [3:0] IterLast = 4'(ITER - 1);

  state_e             state_q, state_d;
  logic [8:0]         r_q, r_d;
  logic signed [8:0]  theta_q, theta_d;
  logic signed [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [3:0]         iter_q, iter_d;
  logic               ph_q, ph_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic signed [9:0]  xo_q, xo_d, yo_q, yo_d;

  logic [15:0]        x0;
  logic               pre_rot;
  logic signed [8:0]  z9;
  logic signed [15:0] x_sh, y_sh, atan;

  function automatic logic signed [15:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    return 16'sd4096;
      4'd1:    return 16'sd2418;
      4'd2:    return 16'sd1278;
      4'd3:    return 16'sd649;
      4'd4:    return 16'sd326;
      4'd5:    return 16'sd163;
      4'd6:    return 16'sd81;
      4'd7:    return 16'sd41;
      4'd8:    return 16'sd20;
      4'd9:    return 16'sd10;
      default: return 16'sd0;
    endcase
  endfunction

  function automatic logic signed [9:0] sat_round(input logic signed [15:0] v);
    logic signed [16:0] t;
    t = ($signed({v[15], v}) + 17'sd32) >>> 6;
    if (t > 17'sd511) begin
      return 10'sd511;
    end else if (t < -17'sd512) begin
      return -10'sd512;
    end
    return t[9:0];
  endfunction

  // R * (1/2 + 1/8 - 1/64 - 1/512) in 6-bit fraction: R*32 + R*8 - R - R/8
  assign x0 = {2'b0, r_q, 5'b0} + {4'b0, r_q, 3'b0} - {7'b0, r_q} - {10'b0, r_q[8:3]};

  // Angles beyond +/-pi/2 are folded by pi; the x sign flip restores the half-plane.
  assign pre_rot = (theta_q > 9'sd128) || (theta_q < -9'sd128);
  assign z9      = pre_rot ? {~theta_q[8], theta_q[7:0]} : theta_q;

  assign x_sh = x_q >>> iter_q;
  assign y_sh = y_q >>> iter_q;
  assign atan = atan_lut(iter_q);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    theta_d = theta_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    ph_d    = ph_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    xo_d    = xo_q;
    yo_d    = yo_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          r_d     = R;
          theta_d = THETA;
          busy_d  = 1'b1;
          ph_d    = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // Two phases keep the prescale adder chain apart from the pre-rotation mux.
        if (!ph_q) begin
          x_d  = $signed(x0);
          y_d  = '0;
          ph_d = 1'b1;
        end else begin
          x_d     = pre_rot ? -x_q : x_q;
          y_d     = '0;
          z_d     = {z9[8], z9, 6'b0};
          iter_d  = '0;
          ph_d    = 1'b0;
          state_d = StIter;
        end
      end
      StIter: begin
        if (!z_q[15]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan;
        end
        if (iter_q == IterLast) begin
          state_d = StOut;
        end else begin
          iter_d = iter_q + 4'd1;
        end
      end
      StOut: begin
        xo_d    = sat_round(x_q);
        yo_d    = sat_round(y_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
      r_q     <= '0;
      theta_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      ph_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      xo_q    <= '0;
      yo_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      theta_q <= theta_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      ph_q    <= ph_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign X    = xo_q;
  assign Y    = yo_q;

endmodule
